vga_driver_gen2: RTL and testbench
==================================

# vga_driver_gen2

Parametrised next-generation VGA timing and pixel engine. Resolution, porch and sync widths, sync polarity and colour depth are all set by parameters. It adds a frame-synchronous mode select with four sources: external pixel stream, colour bars, checkerboard and scrolling gradient. It also adds a valid-qualified pixel fetch handshake with sticky underflow detection, plus frame status outputs. It sits between the clock/reset generation and the board-level RGB/sync pins, with an optional frame-buffer reader on the pixel side.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP / H_SYNC / H_BP, 56 / 120 / 64, horizontal front porch / sync / back porch, in clocks
- V_ACTIVE, 600, visible lines per frame
- V_FP / V_SYNC / V_BP, 37 / 6 / 23, vertical porch and sync widths, in lines
- H_SYNC_POL / V_SYNC_POL, 1 / 1, asserted level of the sync outputs
- COLOR_W, 1, bits per colour channel
- HC_W / VC_W, 11 / 10, counter widths; each must hold H_TOTAL-1 / V_TOTAL-1
- clk  in  1  pixel clock, single clock domain
- reset_  in  1  asynchronous, active-low reset
- i_mode  in  2  source select: 0 external, 1 bars, 2 checker, 3 gradient
- i_pixel_r / i_pixel_g / i_pixel_b  in  COLOR_W each  external pixel data
- i_pixel_valid  in  1  external pixel data valid
- i_clr_underflow  in  1  clears o_underflow
- o_fetch_next_pixel  out  1  external pixel consumed this cycle (ready)
- o_fetch_x / o_fetch_y  out  HC_W / VC_W  coordinates of the pixel being fetched (raw counters)
- o_h_sync / o_v_sync  out  1  registered sync outputs
- o_r / o_g / o_b  out  COLOR_W each  registered colour outputs
- o_vblank  out  1  registered; high on lines >= V_ACTIVE
- o_frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)
- o_frame_cnt  out  8  frames completed, wraps 255->0
- o_underflow  out  1  sticky external-stream underflow flag

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is formed the same way.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments on each h_cnt wrap and counts 0..V_TOTAL-1.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Horizontal sync is asserted while h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). Vertical sync uses the same window on v_cnt.
- mode_q resets to 1 (bars). It loads i_mode only on the edge where the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0), so there are no mid-frame mode changes.
- At that same edge frame_cnt increments.
- Mode 0 (external):
  - o_fetch_next_pixel = active && mode_q==0.
  - With fetch high, i_pixel_* is sampled if i_pixel_valid=1.
  - If i_pixel_valid=0, the pixel is output black and o_underflow is set.
  - No fetch occurs outside active or in modes 1-3.
- Mode 1 (colour bars):
  - BAR_W = H_ACTIVE/8 (integer division).
  - bar = min(7, h_cnt/BAR_W), implemented with a per-line bar counter.
  - r = all bits of bar[2], g = all bits of bar[1], b = all bits of bar[0].
- Mode 2 (checkerboard): white (all ones) when h_cnt[3]^v_cnt[3] = 1, else black.
- Mode 3 (gradient): r = low COLOR_W bits of (h_cnt + frame_cnt); g = low COLOR_W bits of v_cnt; b = 0.
- Colour outputs are 0 whenever not active.
- Underflow flag: set on an underflow, cleared by i_clr_underflow. A simultaneous set and clear leaves the flag set.

## Timing
- Latency: sync, colour, vblank and frame_start are registered. All of them reflect counter state (h_cnt, v_cnt) one cycle after o_fetch_next_pixel / o_fetch_x / o_fetch_y for that position, so all outputs are mutually aligned.
- External data is sampled on the same edge at which fetch is high. A pixel fetched in cycle N appears on o_r/g/b in cycle N+1.
- o_frame_start is high in the cycle o_r/g/b show pixel (0,0) of every frame, including the first frame after reset.
- Reset values while reset_ is low:
  - counters 0, mode_q=1, frame_cnt 0;
  - o_h_sync=!H_SYNC_POL, o_v_sync=!V_SYNC_POL;
  - o_r/g/b 0, o_vblank 0, o_frame_start 0, o_underflow 0, o_fetch_next_pixel 0.
- After reset_ deasserts, the first rising edge registers pixel (0,0) with o_frame_start=1. The first frame is always colour bars.
- Reset asserted mid-frame returns every output to its reset value immediately, asynchronously. On release, timing restarts from (0,0).

## Test plan
- Small timing (H 16/2/4/2, V 8/1/2/1, POL 0/1), release reset:
  - h_sync is low for exactly 4 clocks starting 18 clocks after the pixel-(0,0) output; line period 24;
  - v_sync high for 48 clocks per 288-clock frame;
  - o_frame_start every 288 clocks.
- Mode 1, H_ACTIVE=16, COLOR_W=2: output line reads bar colours 0..7 for 2 pixels each, e.g. pixels 10-11 = r=3, g=0, b=3. Blanking outputs are 0.
- i_mode=0 held from reset:
  - frame 0 shows bars with fetch=0;
  - frame 1 fetch is high exactly 128 cycles per frame (16x8 active);
  - o_r/g/b equal the fed data one cycle later.
- Mode 0 with i_pixel_valid dropped for one active cycle:
  - that pixel outputs black and o_underflow=1 is held;
  - pulsing i_clr_underflow on a clean cycle clears it;
  - a clear coincident with a new underflow leaves it at 1.
- i_mode changed 1->2 mid-frame: the current frame stays bars; the checkerboard starts exactly at the next o_frame_start.
- reset_ asserted at h_cnt=5, v_cnt=3: all outputs take their reset values in the same cycle; after release o_frame_start pulses on the first edge and o_frame_cnt=0.

Source files
------------

// File: rtl/vga_driver_gen2.sv
// Parametrised VGA timing generator and pixel engine with four frame-synchronous sources
// (external stream, colour bars, checkerboard, gradient), fetch handshake and underflow flag.
module vga_driver_gen2 #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 56,
    parameter int H_SYNC     = 120,
    parameter int H_BP       = 64,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 37,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 23,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1,
    parameter int COLOR_W    = 1,
    parameter int HC_W       = 11,
    parameter int VC_W       = 10
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic [1:0]         i_mode,
    input  logic [COLOR_W-1:0] i_pixel_r,
    input  logic [COLOR_W-1:0] i_pixel_g,
    input  logic [COLOR_W-1:0] i_pixel_b,
    input  logic               i_pixel_valid,
    input  logic               i_clr_underflow,
    output logic               o_fetch_next_pixel,
    output logic [HC_W-1:0]    o_fetch_x,
    output logic [VC_W-1:0]    o_fetch_y,
    output logic               o_h_sync,
    output logic               o_v_sync,
    output logic [COLOR_W-1:0] o_r,
    output logic [COLOR_W-1:0] o_g,
    output logic [COLOR_W-1:0] o_b,
    output logic               o_vblank,
    output logic               o_frame_start,
    output logic [7:0]         o_frame_cnt,
    output logic               o_underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_ACT    = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] H_SS     = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] H_SE     = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HC_W-1:0] H_ONE    = HC_W'(1);
    localparam logic [HC_W-1:0] H_ZERO   = HC_W'(0);
    localparam logic [HC_W-1:0] BAR_LAST = HC_W'(BAR_W - 1);
    localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT    = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] V_SS     = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] V_SE     = VC_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VC_W-1:0] V_ONE    = VC_W'(1);
    localparam logic [VC_W-1:0] V_ZERO   = VC_W'(0);

    typedef enum logic [1:0] {
        MODE_EXT   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_e;

    logic [HC_W-1:0]    r_h_cnt;
    logic [VC_W-1:0]    r_v_cnt;
    mode_e              r_mode;
    logic [7:0]         r_frame_cnt;
    logic [2:0]         r_bar;
    logic [HC_W-1:0]    r_bar_px;
    logic               r_h_sync;
    logic               r_v_sync;
    logic [COLOR_W-1:0] r_r;
    logic [COLOR_W-1:0] r_g;
    logic [COLOR_W-1:0] r_b;
    logic               r_vblank;
    logic               r_frame_start;
    logic               r_underflow;

    logic               w_h_last;
    logic               w_frame_wrap;
    logic               w_active;
    logic               w_fetch;
    logic               w_underflow_evt;
    logic [HC_W-1:0]    w_grad_sum;
    logic [COLOR_W-1:0] w_r;
    logic [COLOR_W-1:0] w_g;
    logic [COLOR_W-1:0] w_b;

    assign w_h_last        = (r_h_cnt == H_LAST);
    assign w_frame_wrap    = w_h_last && (r_v_cnt == V_LAST);
    assign w_active        = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_fetch         = w_active && (r_mode == MODE_EXT);
    assign w_underflow_evt = w_fetch && !i_pixel_valid;
    assign w_grad_sum      = r_h_cnt + HC_W'(r_frame_cnt);

    // Raster position counters
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_h_cnt <= H_ZERO;
            r_v_cnt <= V_ZERO;
        end else if (w_h_last) begin
            r_h_cnt <= H_ZERO;
            r_v_cnt <= (r_v_cnt == V_LAST) ? V_ZERO : (r_v_cnt + V_ONE);
        end else begin
            r_h_cnt <= r_h_cnt + H_ONE;
            r_v_cnt <= r_v_cnt;
        end
    end

    // Mode and frame counter only change at the frame boundary, so a frame is never split
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_mode      <= MODE_BARS;
            r_frame_cnt <= 8'd0;
        end else if (w_frame_wrap) begin
            r_mode      <= mode_e'(i_mode);
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end else begin
            r_mode      <= r_mode;
            r_frame_cnt <= r_frame_cnt;
        end
    end

    // Per-line bar index; avoids a divider by counting BAR_W pixels per bar, saturating at 7
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_bar    <= 3'd0;
            r_bar_px <= H_ZERO;
        end else if (w_h_last) begin
            r_bar    <= 3'd0;
            r_bar_px <= H_ZERO;
        end else if ((r_h_cnt < H_ACT) && (r_bar_px == BAR_LAST)) begin
            r_bar    <= (r_bar == 3'd7) ? 3'd7 : (r_bar + 3'd1);
            r_bar_px <= H_ZERO;
        end else if (r_h_cnt < H_ACT) begin
            r_bar    <= r_bar;
            r_bar_px <= r_bar_px + H_ONE;
        end else begin
            r_bar    <= r_bar;
            r_bar_px <= r_bar_px;
        end
    end

    // Pixel source selection; everything outside the active area is black
    always_comb begin
        w_r = {COLOR_W{1'b0}};
        w_g = {COLOR_W{1'b0}};
        w_b = {COLOR_W{1'b0}};
        if (w_active) begin
            case (r_mode)
                MODE_EXT: begin
                    if (i_pixel_valid) begin
                        w_r = i_pixel_r;
                        w_g = i_pixel_g;
                        w_b = i_pixel_b;
                    end else begin
                        w_r = {COLOR_W{1'b0}};
                    end
                end
                MODE_BARS: begin
                    w_r = {COLOR_W{r_bar[2]}};
                    w_g = {COLOR_W{r_bar[1]}};
                    w_b = {COLOR_W{r_bar[0]}};
                end
                MODE_CHECK: begin
                    w_r = {COLOR_W{r_h_cnt[3] ^ r_v_cnt[3]}};
                    w_g = {COLOR_W{r_h_cnt[3] ^ r_v_cnt[3]}};
                    w_b = {COLOR_W{r_h_cnt[3] ^ r_v_cnt[3]}};
                end
                MODE_GRAD: begin
                    w_r = w_grad_sum[COLOR_W-1:0];
                    w_g = r_v_cnt[COLOR_W-1:0];
                end
                default: begin
                    w_r = {COLOR_W{1'b0}};
                end
            endcase
        end else begin
            w_r = {COLOR_W{1'b0}};
        end
    end

    // Output pipeline stage: all video outputs lag the fetch position by one clock
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_h_sync      <= !H_SYNC_POL;
            r_v_sync      <= !V_SYNC_POL;
            r_r           <= {COLOR_W{1'b0}};
            r_g           <= {COLOR_W{1'b0}};
            r_b           <= {COLOR_W{1'b0}};
            r_vblank      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_h_sync      <= ((r_h_cnt >= H_SS) && (r_h_cnt < H_SE)) ? H_SYNC_POL : !H_SYNC_POL;
            r_v_sync      <= ((r_v_cnt >= V_SS) && (r_v_cnt < V_SE)) ? V_SYNC_POL : !V_SYNC_POL;
            r_r           <= w_r;
            r_g           <= w_g;
            r_b           <= w_b;
            r_vblank      <= (r_v_cnt >= V_ACT);
            r_frame_start <= (r_h_cnt == H_ZERO) && (r_v_cnt == V_ZERO);
        end
    end

    // Sticky underflow: a new event wins over a coincident clear
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_underflow <= 1'b0;
        end else if (w_underflow_evt) begin
            r_underflow <= 1'b1;
        end else if (i_clr_underflow) begin
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= r_underflow;
        end
    end

    assign o_fetch_next_pixel = w_fetch;
    assign o_fetch_x          = r_h_cnt;
    assign o_fetch_y          = r_v_cnt;
    assign o_h_sync           = r_h_sync;
    assign o_v_sync           = r_v_sync;
    assign o_r                = r_r;
    assign o_g                = r_g;
    assign o_b                = r_b;
    assign o_vblank           = r_vblank;
    assign o_frame_start      = r_frame_start;
    assign o_frame_cnt        = r_frame_cnt;
    assign o_underflow        = r_underflow;

endmodule

// File: tb/tb_vga_driver_gen2.sv
// Scoreboard bench for vga_driver_gen2 on a 24x12 raster (16x8 active, 2-bit colour).
module tb_vga_driver_gen2;

    localparam int HA = 16;
    localparam int HT = 24;
    localparam int VA = 8;
    localparam int VT = 12;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic [1:0] i_mode = 2'd0;
    logic [1:0] i_pixel_r = 2'd0;
    logic [1:0] i_pixel_g = 2'd0;
    logic [1:0] i_pixel_b = 2'd0;
    logic       i_pixel_valid = 1'b0;
    logic       i_clr_underflow = 1'b0;

    logic       o_fetch_next_pixel;
    logic [4:0] o_fetch_x;
    logic [3:0] o_fetch_y;
    logic       o_h_sync, o_v_sync, o_vblank, o_frame_start, o_underflow;
    logic [1:0] o_r, o_g, o_b;
    logic [7:0] o_frame_cnt;

    int n_vec = 0;
    int n_err = 0;
    int m_h, m_v, m_mode, m_fcnt, m_uf;
    int fetch_seen = 0;
    logic [18:0] sb[$];

    vga_driver_gen2 #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1),
        .COLOR_W(2), .HC_W(5), .VC_W(4)
    ) dut (
        .clk(clk), .reset_(reset_), .i_mode(i_mode),
        .i_pixel_r(i_pixel_r), .i_pixel_g(i_pixel_g), .i_pixel_b(i_pixel_b),
        .i_pixel_valid(i_pixel_valid), .i_clr_underflow(i_clr_underflow),
        .o_fetch_next_pixel(o_fetch_next_pixel), .o_fetch_x(o_fetch_x), .o_fetch_y(o_fetch_y),
        .o_h_sync(o_h_sync), .o_v_sync(o_v_sync), .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_vblank(o_vblank), .o_frame_start(o_frame_start), .o_frame_cnt(o_frame_cnt),
        .o_underflow(o_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_h = 0; m_v = 0; m_mode = 1; m_fcnt = 0; m_uf = 0;
        sb.delete();
    endtask

    // One clock: check fetch outputs, push expected registered outputs, advance model, pop and compare
    task automatic cycle();
        logic [1:0] er, eg, eb;
        logic act, efetch, hs, vs, vb, fs;
        logic [18:0] exp_v, got_v;
        int bar, uf_n;
        act = (m_h < HA) && (m_v < VA);
        efetch = act && (m_mode == 0);
        n_vec++;
        if ({o_fetch_next_pixel, o_fetch_x, o_fetch_y} !== {efetch, 5'(m_h), 4'(m_v)}) begin
            n_err++;
            $display("FAIL fetch at h=%0d v=%0d: got %h expected %h", m_h, m_v,
                     {o_fetch_next_pixel, o_fetch_x, o_fetch_y}, {efetch, 5'(m_h), 4'(m_v)});
        end
        if (o_fetch_next_pixel === 1'b1) fetch_seen++;
        er = 2'd0; eg = 2'd0; eb = 2'd0;
        if (act) begin
            case (m_mode)
                0: if (i_pixel_valid) begin er = i_pixel_r; eg = i_pixel_g; eb = i_pixel_b; end
                1: begin
                    bar = (m_h / 2 > 7) ? 7 : m_h / 2;
                    er = {2{bar[2]}}; eg = {2{bar[1]}}; eb = {2{bar[0]}};
                end
                2: if ((((m_h >> 3) ^ (m_v >> 3)) & 1) == 1) begin er = 2'd3; eg = 2'd3; eb = 2'd3; end
                default: begin er = 2'((m_h + m_fcnt) % 4); eg = 2'(m_v % 4); end
            endcase
        end
        hs = (m_h >= 18 && m_h < 22) ? 1'b0 : 1'b1;
        vs = (m_v >= 9 && m_v < 11) ? 1'b1 : 1'b0;
        vb = (m_v >= VA);
        fs = (m_h == 0) && (m_v == 0);
        uf_n = (efetch && !i_pixel_valid) ? 1 : (i_clr_underflow ? 0 : m_uf);
        m_uf = uf_n;
        if (m_h == HT - 1) begin
            m_h = 0;
            if (m_v == VT - 1) begin
                m_v = 0; m_mode = int'(i_mode); m_fcnt = (m_fcnt + 1) % 256;
            end else m_v++;
        end else m_h++;
        sb.push_back({hs, vs, er, eg, eb, vb, fs, 1'(uf_n), 8'(m_fcnt)});
        @(posedge clk);
        @(negedge clk);
        exp_v = sb.pop_front();
        got_v = {o_h_sync, o_v_sync, o_r, o_g, o_b, o_vblank, o_frame_start, o_underflow, o_frame_cnt};
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL outputs {hs,vs,r,g,b,vblank,fs,uf,fcnt}: got %h expected %h", got_v, exp_v);
        end
    endtask

    task automatic run_until(input int h, input int v);
        for (int k = 0; k < 400 && !(m_h == h && m_v == v); k++) cycle();
        n_vec++;
        if (!(m_h == h && m_v == v)) begin
            n_err++;
            $display("FAIL run_until: reached h=%0d v=%0d wanted h=%0d v=%0d", m_h, m_v, h, v);
        end
    endtask

    task automatic test_reset();
        logic [28:0] rst_exp;
        rst_exp = {1'b1, 28'd0};
        reset_ = 1'b0;
        i_mode = 2'd0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({o_h_sync, o_v_sync, o_r, o_g, o_b, o_vblank, o_frame_start, o_underflow, o_frame_cnt,
             o_fetch_next_pixel, o_fetch_x, o_fetch_y} !== rst_exp) begin
            n_err++;
            $display("FAIL reset_values: got %h expected %h", {o_h_sync, o_v_sync, o_r, o_g, o_b,
                     o_vblank, o_frame_start, o_underflow, o_frame_cnt, o_fetch_next_pixel,
                     o_fetch_x, o_fetch_y}, rst_exp);
        end
        reset_ = 1'b1;
        model_reset();
    endtask

    task automatic test_timing();
        int hs_low, vs_high, first_hs, fs_cnt, fs_t;
        logic [5:0] rgb10, rgb11;
        hs_low = 0; vs_high = 0; first_hs = -1; fs_cnt = 0; fs_t = -1;
        rgb10 = 6'd0; rgb11 = 6'd0;
        fetch_seen = 0;
        for (int t = 0; t < 288; t++) begin
            cycle();
            if (o_h_sync === 1'b0) begin hs_low++; if (first_hs < 0) first_hs = t; end
            if (o_v_sync === 1'b1) vs_high++;
            if (o_frame_start === 1'b1) begin fs_cnt++; fs_t = t; end
            if (t == 10) rgb10 = {o_r, o_g, o_b};
            if (t == 11) rgb11 = {o_r, o_g, o_b};
        end
        n_vec++; if (first_hs != 18) begin n_err++; $display("FAIL hsync_start: got %0d expected 18", first_hs); end
        n_vec++; if (hs_low != 48) begin n_err++; $display("FAIL hsync_low_count: got %0d expected 48", hs_low); end
        n_vec++; if (vs_high != 48) begin n_err++; $display("FAIL vsync_high_count: got %0d expected 48", vs_high); end
        n_vec++; if (fs_cnt != 1 || fs_t != 0) begin n_err++; $display("FAIL frame_start_once: got cnt=%0d t=%0d expected 1 at 0", fs_cnt, fs_t); end
        n_vec++; if (rgb10 !== 6'b110011) begin n_err++; $display("FAIL bar_px10: got %b expected 110011", rgb10); end
        n_vec++; if (rgb11 !== 6'b110011) begin n_err++; $display("FAIL bar_px11: got %b expected 110011", rgb11); end
        n_vec++; if (fetch_seen != 0) begin n_err++; $display("FAIL frame0_no_fetch: got %0d expected 0", fetch_seen); end
    endtask

    task automatic test_external();
        logic f;
        logic [5:0] fed;
        fetch_seen = 0;
        i_pixel_valid = 1'b1;
        for (int t = 0; t < 288; t++) begin
            i_pixel_r = 2'($urandom); i_pixel_g = 2'($urandom); i_pixel_b = 2'($urandom);
            f = o_fetch_next_pixel;
            fed = {i_pixel_r, i_pixel_g, i_pixel_b};
            cycle();
            if (t == 0) begin
                n_vec++;
                if (o_frame_start !== 1'b1 || o_frame_cnt !== 8'd1) begin
                    n_err++;
                    $display("FAIL frame1_start: got fs=%b cnt=%0d expected 1/1", o_frame_start, o_frame_cnt);
                end
            end
            if (f === 1'b1) begin
                n_vec++;
                if ({o_r, o_g, o_b} !== fed) begin
                    n_err++;
                    $display("FAIL ext_pixel t=%0d: got %h expected %h", t, {o_r, o_g, o_b}, fed);
                end
            end
        end
        n_vec++;
        if (fetch_seen != 128) begin n_err++; $display("FAIL fetch_count: got %0d expected 128", fetch_seen); end
    endtask

    task automatic test_underflow();
        run_until(3, 1);
        i_pixel_valid = 1'b0;
        cycle();
        i_pixel_valid = 1'b1;
        n_vec++;
        if ({o_underflow, o_r, o_g, o_b} !== 7'b1_000000) begin
            n_err++; $display("FAIL underflow_set: got %b expected 1000000", {o_underflow, o_r, o_g, o_b});
        end
        repeat (5) cycle();
        n_vec++;
        if (o_underflow !== 1'b1) begin n_err++; $display("FAIL underflow_sticky: got %b expected 1", o_underflow); end
        i_clr_underflow = 1'b1;
        cycle();
        i_clr_underflow = 1'b0;
        n_vec++;
        if (o_underflow !== 1'b0) begin n_err++; $display("FAIL underflow_clear: got %b expected 0", o_underflow); end
        run_until(7, 2);
        i_pixel_valid = 1'b0;
        i_clr_underflow = 1'b1;
        cycle();
        i_pixel_valid = 1'b1;
        i_clr_underflow = 1'b0;
        n_vec++;
        if (o_underflow !== 1'b1) begin n_err++; $display("FAIL underflow_set_wins: got %b expected 1", o_underflow); end
        i_clr_underflow = 1'b1;
        cycle();
        i_clr_underflow = 1'b0;
        n_vec++;
        if (o_underflow !== 1'b0) begin n_err++; $display("FAIL underflow_reclear: got %b expected 0", o_underflow); end
    endtask

    task automatic test_mode_switch();
        i_mode = 2'd1;
        run_until(0, 0);
        cycle();
        run_until(0, 4);
        i_mode = 2'd2;
        run_until(8, 5);
        cycle();
        n_vec++;
        if ({o_r, o_g, o_b} !== 6'b110000) begin
            n_err++; $display("FAIL bars_hold_after_switch: got %b expected 110000", {o_r, o_g, o_b});
        end
        run_until(0, 0);
        cycle();
        n_vec++;
        if (o_frame_start !== 1'b1) begin n_err++; $display("FAIL checker_frame_start: got %b expected 1", o_frame_start); end
        run_until(8, 0);
        cycle();
        n_vec++;
        if ({o_r, o_g, o_b} !== 6'b111111) begin
            n_err++; $display("FAIL checker_px8: got %b expected 111111", {o_r, o_g, o_b});
        end
        i_mode = 2'd3;
        run_until(0, 0);
        run_until(12, 6);
        cycle();
    endtask

    task automatic test_reset_midframe();
        logic [28:0] rst_exp;
        rst_exp = {1'b1, 28'd0};
        run_until(5, 3);
        reset_ = 1'b0;
        #1;
        n_vec++;
        if ({o_h_sync, o_v_sync, o_r, o_g, o_b, o_vblank, o_frame_start, o_underflow, o_frame_cnt,
             o_fetch_next_pixel, o_fetch_x, o_fetch_y} !== rst_exp) begin
            n_err++;
            $display("FAIL async_reset_values: got %h expected %h", {o_h_sync, o_v_sync, o_r, o_g, o_b,
                     o_vblank, o_frame_start, o_underflow, o_frame_cnt, o_fetch_next_pixel,
                     o_fetch_x, o_fetch_y}, rst_exp);
        end
        @(negedge clk);
        reset_ = 1'b1;
        model_reset();
        cycle();
        n_vec++;
        if (o_frame_start !== 1'b1 || o_frame_cnt !== 8'd0) begin
            n_err++; $display("FAIL restart_frame: got fs=%b cnt=%0d expected 1/0", o_frame_start, o_frame_cnt);
        end
        repeat (30) cycle();
    endtask

    initial begin
        test_reset();
        test_timing();
        test_external();
        test_underflow();
        test_mode_switch();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
